// File: rtl/pkfb_pkg.sv
//============================================================================
// Module      : pkfb_pkg
// Description : Register map, CTRL/STATUS bit positions and FSM states for
//               the packet FIFO Wishbone writer.
// Revision    : 1.0 - initial release
//============================================================================
`default_nettype none

package pkfb_pkg;

    localparam logic [1:0] c_reg_data   = 2'd0;
    localparam logic [1:0] c_reg_ctrl   = 2'd1;
    localparam logic [1:0] c_reg_status = 2'd2;

    localparam int c_ctrl_send     = 0;
    localparam int c_ctrl_irq_en   = 1;
    localparam int c_ctrl_clr_ovf  = 8;
    localparam int c_ctrl_clr_drop = 9;

    localparam int c_stat_busy      = 0;
    localparam int c_stat_irq_en    = 2;
    localparam int c_stat_count_lsb = 4;
    localparam int c_stat_count_w   = 5;
    localparam int c_stat_ovf       = 12;
    localparam int c_stat_drop      = 13;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_PUSH = 2'd1,
        ST_DONE = 2'd2
    } pkfb_state_e;

endpackage

`default_nettype wire

// File: rtl/pkfb_sync_fifo.sv
//============================================================================
// Module      : pkfb_sync_fifo
// Description : Single-clock first-word-fall-through FIFO with saturating
//               occupancy count.
// Revision    : 1.0 - initial release
//============================================================================
`default_nettype none

module pkfb_sync_fifo #(
    parameter int DEPTH = 8,
    parameter int WIDTH = 32
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   i_push,
    input  logic [WIDTH-1:0]       i_wr_data,
    input  logic                   i_pop,
    output logic [WIDTH-1:0]       o_rd_data,
    output logic                   o_full,
    output logic                   o_empty,
    output logic [$clog2(DEPTH):0] o_count
);

    localparam int               c_aw   = $clog2(DEPTH);
    localparam logic [c_aw:0]    c_full = (c_aw + 1)'(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [c_aw-1:0]  r_wr_ptr;
    logic [c_aw-1:0]  r_rd_ptr;
    logic [c_aw:0]    r_count;
    logic             w_do_push;
    logic             w_do_pop;

    // Requests against a full/empty FIFO are refused here, so the count can never wrap.
    assign w_do_push = i_push & ~o_full;
    assign w_do_pop  = i_pop & ~o_empty;

    always_ff @(posedge clk) begin
        if (w_do_push) begin
            r_mem[r_wr_ptr] <= i_wr_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) begin
                r_wr_ptr <= r_wr_ptr + c_aw'(1);
            end
            if (w_do_pop) begin
                r_rd_ptr <= r_rd_ptr + c_aw'(1);
            end
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + (c_aw + 1)'(1);
                2'b01:   r_count <= r_count - (c_aw + 1)'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    assign o_rd_data = r_mem[r_rd_ptr];
    assign o_full    = (r_count == c_full);
    assign o_empty   = (r_count == '0);
    assign o_count   = r_count;

endmodule

`default_nettype wire

// File: rtl/pkfb_wb_writer.sv
//============================================================================
// Module      : pkfb_wb_writer
// Description : Wishbone slave that buffers DATA writes and streams them as
//               one SOF/EOF-framed packet into the packet FIFO on SEND.
//               Optional packet-done interrupt: PKFB_WB_WRITER_IRQ_EN.
// Revision    : 1.0 - initial release
//============================================================================
`default_nettype none

module pkfb_wb_writer #(
    parameter int FIFO_DEPTH = 8
) (
    input  logic        WB_CLK,
    input  logic        WB_RST_N,
    input  logic        WBs_CYC,
    input  logic        WBs_STB,
    input  logic        WBs_WE,
    input  logic [3:0]  WBs_BYTE_STB,
    input  logic [16:0] WBs_ADR,
    input  logic [31:0] WBs_WR_DAT,
    output logic [31:0] WBs_RD_DAT,
    output logic        WBs_ACK,
    output logic [31:0] FB_PKfbData,
    output logic [3:0]  FB_PKfbPush,
    output logic        FB_PKfbSOF,
    output logic        FB_PKfbEOF,
    input  logic        FB_PKfbOverflow,
    output logic        Pkt_Done_Irq
);

    import pkfb_pkg::*;

    localparam int c_cw = $clog2(FIFO_DEPTH) + 1;

    pkfb_state_e      r_state;
    pkfb_state_e      w_state_nxt;
    logic             r_ack;
    logic [31:0]      r_rd_dat;
    logic             r_send_pend;
    logic [c_cw-1:0]  r_len;
    logic [c_cw-1:0]  r_idx;
    logic             r_ovf;
    logic             r_drop;
    logic [31:0]      r_fb_data;
    logic [3:0]       r_fb_push;
    logic             r_fb_sof;
    logic             r_fb_eof;

    logic             w_req;
    logic [1:0]       w_adr;
    logic             w_data_wr;
    logic             w_ctrl_wr;
    logic             w_status_rd;
    logic             w_send_ok;
    logic             w_pop;
    logic             w_busy;
    logic             w_irq_en;
    logic [c_cw-1:0]  w_last_idx;
    logic [31:0]      w_status;
    logic [31:0]      w_fifo_rd_data;
    logic             w_fifo_full;
    logic             w_fifo_empty;
    logic [c_cw-1:0]  w_fifo_count;
    logic             w_unused;

    assign w_unused = ^{WBs_BYTE_STB, WBs_ADR[16:4], WBs_ADR[1:0]};

    // A request is only taken in its first cycle; the ACK cycle masks it.
    assign w_req       = WBs_CYC & WBs_STB & ~r_ack;
    assign w_adr       = WBs_ADR[3:2];
    assign w_data_wr   = w_req & WBs_WE & (w_adr == c_reg_data);
    assign w_ctrl_wr   = w_req & WBs_WE & (w_adr == c_reg_ctrl);
    assign w_status_rd = w_req & ~WBs_WE & (w_adr == c_reg_status);
    assign w_send_ok   = w_ctrl_wr & WBs_WR_DAT[c_ctrl_send] & (r_state == ST_IDLE)
                       & ~r_send_pend & (w_fifo_count != '0);
    assign w_last_idx  = r_len - c_cw'(1);

    pkfb_sync_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (32)
    ) u_fifo (
        .clk       (WB_CLK),
        .rst_n     (WB_RST_N),
        .i_push    (w_data_wr),
        .i_wr_data (WBs_WR_DAT),
        .i_pop     (w_pop),
        .o_rd_data (w_fifo_rd_data),
        .o_full    (w_fifo_full),
        .o_empty   (w_fifo_empty),
        .o_count   (w_fifo_count)
    );

    always_ff @(posedge WB_CLK or negedge WB_RST_N) begin
        if (!WB_RST_N) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // The SEND is held pending for one cycle so the first word lands two cycles after ACK.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: if (r_send_pend) w_state_nxt = ST_PUSH;
            ST_PUSH: if (w_pop && (r_idx == w_last_idx)) w_state_nxt = ST_DONE;
            ST_DONE: w_state_nxt = ST_IDLE;
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        w_pop  = (r_state == ST_PUSH) & ~w_fifo_empty;
        w_busy = (r_state != ST_IDLE);
    end

    always_comb begin
        w_status = '0;
        w_status[c_stat_busy]                             = w_busy;
        w_status[c_stat_irq_en]                           = w_irq_en;
        w_status[c_stat_count_lsb +: c_stat_count_w]      = c_stat_count_w'(w_fifo_count);
        w_status[c_stat_ovf]                              = r_ovf;
        w_status[c_stat_drop]                             = r_drop;
    end

    always_ff @(posedge WB_CLK or negedge WB_RST_N) begin
        if (!WB_RST_N) begin
            r_ack       <= 1'b0;
            r_rd_dat    <= '0;
            r_send_pend <= 1'b0;
            r_len       <= '0;
            r_idx       <= '0;
            r_ovf       <= 1'b0;
            r_drop      <= 1'b0;
            r_fb_data   <= '0;
            r_fb_push   <= '0;
            r_fb_sof    <= 1'b0;
            r_fb_eof    <= 1'b0;
        end else begin
            r_ack       <= w_req;
            r_rd_dat    <= w_status_rd ? w_status : '0;
            r_send_pend <= w_send_ok;
            if (w_send_ok) begin
                r_len <= w_fifo_count;
                r_idx <= '0;
            end else if (w_pop) begin
                r_idx <= r_idx + c_cw'(1);
            end
            if (w_pop) begin
                r_fb_data <= w_fifo_rd_data;
                r_fb_push <= 4'b1111;
                r_fb_sof  <= (r_idx == '0);
                r_fb_eof  <= (r_idx == w_last_idx);
            end else begin
                r_fb_push <= '0;
                r_fb_sof  <= 1'b0;
                r_fb_eof  <= 1'b0;
            end
            // A new overflow event wins over a clear in the same cycle.
            if (w_ctrl_wr && WBs_WR_DAT[c_ctrl_clr_ovf]) r_ovf <= 1'b0;
            if ((|r_fb_push) && FB_PKfbOverflow)         r_ovf <= 1'b1;
            if (w_ctrl_wr && WBs_WR_DAT[c_ctrl_clr_drop]) r_drop <= 1'b0;
            if (w_data_wr && w_fifo_full)                r_drop <= 1'b1;
        end
    end

`ifdef PKFB_WB_WRITER_IRQ_EN
    logic r_irq_en;

    always_ff @(posedge WB_CLK or negedge WB_RST_N) begin
        if (!WB_RST_N) begin
            r_irq_en <= 1'b0;
        end else if (w_ctrl_wr) begin
            r_irq_en <= WBs_WR_DAT[c_ctrl_irq_en];
        end
    end

    assign w_irq_en     = r_irq_en;
    assign Pkt_Done_Irq = r_irq_en & (r_state == ST_DONE);
`else
    assign w_irq_en     = 1'b0;
    assign Pkt_Done_Irq = 1'b0;
`endif

    assign WBs_ACK     = r_ack;
    assign WBs_RD_DAT  = r_rd_dat;
    assign FB_PKfbData = r_fb_data;
    assign FB_PKfbPush = r_fb_push;
    assign FB_PKfbSOF  = r_fb_sof;
    assign FB_PKfbEOF  = r_fb_eof;

endmodule

`default_nettype wire

// File: tb/tb_pkfb_wb_writer.sv
//============================================================================
// Module      : tb_pkfb_wb_writer
// Description : Directed self-checking bench for pkfb_wb_writer with a
//               queue-based packet model and a per-cycle compare process.
// Revision    : 1.0 - initial release
//============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_pkfb_wb_writer;

    localparam int DEPTH = 8;
`ifdef PKFB_WB_WRITER_IRQ_EN
    localparam logic [31:0] IRQ_ST   = 32'h4;
    localparam logic [31:0] IRQ_NPKT = 32'd2;
`else
    localparam logic [31:0] IRQ_ST   = 32'h0;
    localparam logic [31:0] IRQ_NPKT = 32'd0;
`endif

    logic        clk;
    logic        rst_n;
    logic        cyc;
    logic        stb;
    logic        we;
    logic [3:0]  bsel;
    logic [16:0] adr;
    logic [31:0] wdat;
    logic [31:0] rdat;
    logic        ack;
    logic [31:0] fb_data;
    logic [3:0]  fb_push;
    logic        fb_sof;
    logic        fb_eof;
    logic        ovf_in;
    logic        irq;

    pkfb_wb_writer #(.FIFO_DEPTH(DEPTH)) dut (
        .WB_CLK          (clk),
        .WB_RST_N        (rst_n),
        .WBs_CYC         (cyc),
        .WBs_STB         (stb),
        .WBs_WE          (we),
        .WBs_BYTE_STB    (bsel),
        .WBs_ADR         (adr),
        .WBs_WR_DAT      (wdat),
        .WBs_RD_DAT      (rdat),
        .WBs_ACK         (ack),
        .FB_PKfbData     (fb_data),
        .FB_PKfbPush     (fb_push),
        .FB_PKfbSOF      (fb_sof),
        .FB_PKfbEOF      (fb_eof),
        .FB_PKfbOverflow (ovf_in),
        .Pkt_Done_Irq    (irq)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int vectors     = 0;
    int miscompares = 0;
    int cycle       = 0;
    int irq_count   = 0;
    logic prev_ack  = 1'b0;

    always @(posedge clk) cycle <= cycle + 1;

    // Model: words waiting in the FIFO, and the packet words owed at exact cycles.
    typedef struct {
        int          cyc;
        logic [31:0] data;
        logic        sof;
        logic        eof;
    } exp_t;

    logic [31:0] m_fifo[$];
    exp_t        exp_q[$];
    int          irq_q[$];
    logic        m_ovf;
    logic        m_drop;
    logic        m_irq_en;
    logic [31:0] m_last_data;
    int          busy_start;
    int          busy_end;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h (cycle %0d)", name, act, exp, cycle);
        end
    endtask

    task automatic model_reset();
        m_fifo.delete();
        exp_q.delete();
        irq_q.delete();
        m_ovf       = 1'b0;
        m_drop      = 1'b0;
        m_irq_en    = 1'b0;
        m_last_data = 32'd0;
        busy_start  = -100;
        busy_end    = -100;
    endtask

    function automatic logic [31:0] m_status(input int k);
        logic [31:0] s;
        s       = 32'd0;
        s[0]    = (k >= busy_start) && (k <= busy_end);
        s[2]    = m_irq_en;
        s[8:4]  = 5'(m_fifo.size());
        s[12]   = m_ovf;
        s[13]   = m_drop;
        return s;
    endfunction

    task automatic model_write(input logic [1:0] a, input logic [31:0] d, input int k);
        int len;
        exp_t e;
        if (a == 2'd0) begin
            if (m_fifo.size() < DEPTH) m_fifo.push_back(d);
            else                       m_drop = 1'b1;
        end else if (a == 2'd1) begin
            if (d[8]) m_ovf  = 1'b0;
            if (d[9]) m_drop = 1'b0;
`ifdef PKFB_WB_WRITER_IRQ_EN
            m_irq_en = d[1];
`endif
            if (d[0] && (k > busy_end) && (m_fifo.size() > 0)) begin
                len        = m_fifo.size();
                busy_start = k + 2;
                busy_end   = k + 2 + len;
                for (int i = 0; i < len; i++) begin
                    e.cyc  = k + 3 + i;
                    e.data = m_fifo.pop_front();
                    e.sof  = (i == 0);
                    e.eof  = (i == len - 1);
                    exp_q.push_back(e);
                end
                if (m_irq_en) irq_q.push_back(k + 2 + len);
            end
        end
    endtask

    always @(negedge clk) begin : compare
        exp_t e;
        logic exp_irq;
        if (exp_q.size() > 0 && exp_q[0].cyc == cycle) begin
            e = exp_q.pop_front();
            check("push_strobe", 32'(fb_push), 32'hF);
            check("push_data",   fb_data, e.data);
            check("push_sof",    32'(fb_sof), 32'(e.sof));
            check("push_eof",    32'(fb_eof), 32'(e.eof));
            m_last_data = e.data;
            if (ovf_in) m_ovf = 1'b1;
        end else begin
            check("idle_push", 32'(fb_push), 32'd0);
            check("idle_sof",  32'(fb_sof), 32'd0);
            check("idle_eof",  32'(fb_eof), 32'd0);
            check("idle_data_hold", fb_data, m_last_data);
        end
        exp_irq = (irq_q.size() > 0) && (irq_q[0] == cycle);
        if (exp_irq) void'(irq_q.pop_front());
        check("irq", 32'(irq), 32'(exp_irq));
        if (irq) irq_count++;
        if (!ack) check("rd_dat_idle", rdat, 32'd0);
        check("ack_single", 32'(ack & prev_ack), 32'd0);
        prev_ack = ack;
    end

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic wb_access(input logic w, input logic [1:0] a, input logic [31:0] d,
                             output logic [31:0] rv);
        cyc  = 1'b1;
        stb  = 1'b1;
        we   = w;
        adr  = {13'h0A5, a, 2'b01};
        wdat = d;
        @(posedge clk);
        #1;
        check("ack", 32'(ack), 32'd1);
        rv   = rdat;
        cyc  = 1'b0;
        stb  = 1'b0;
        we   = 1'b0;
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [1:0] a, input logic [31:0] d, output int k);
        logic [31:0] rv;
        k = cycle;
        model_write(a, d, k);
        wb_access(1'b1, a, d, rv);
    endtask

    task automatic rd(input string name, input logic [1:0] a, output logic [31:0] v);
        logic [31:0] exp;
        exp = (a == 2'd2) ? m_status(cycle) : 32'd0;
        wb_access(1'b0, a, 32'd0, v);
        check(name, v, exp);
    endtask

    initial begin : stim
        logic [31:0] v;
        int k;
        rst_n  = 1'b0;
        cyc    = 1'b0;
        stb    = 1'b0;
        we     = 1'b0;
        bsel   = 4'hF;
        adr    = '0;
        wdat   = '0;
        ovf_in = 1'b0;
        model_reset();

        idle(3);
        check("rst_ack",  32'(ack), 32'd0);
        check("rst_rdat", rdat, 32'd0);
        check("rst_data", fb_data, 32'd0);
        check("rst_push", 32'(fb_push), 32'd0);
        check("rst_sof",  32'(fb_sof), 32'd0);
        check("rst_eof",  32'(fb_eof), 32'd0);
        check("rst_irq",  32'(irq), 32'd0);
        rst_n = 1'b1;
        idle(1);
        rd("status_rd", 2'd2, v);
        check("status_after_reset", v, 32'h0);
        wr(2'd3, 32'hFFFF_FFFF, k);
        rd("reserved_rd", 2'd3, v);
        check("reserved_zero", v, 32'h0);

        // Three-word packet.
        wr(2'd0, 32'hA0, k);
        wr(2'd0, 32'hA1, k);
        wr(2'd0, 32'hA2, k);
        rd("status_rd", 2'd2, v);
        check("status_count3", v, 32'h30);
        wr(2'd1, 32'h1, k);
        idle(8);
        rd("status_rd", 2'd2, v);
        check("status_after_pkt3", v, 32'h0);
        check("data_hold_a2", fb_data, 32'hA2);

        // Single-word packet: SOF and EOF together.
        wr(2'd0, 32'h55, k);
        wr(2'd1, 32'h1, k);
        idle(6);
        check("data_hold_55", fb_data, 32'h55);

        // Overfill: nine writes into eight entries.
        for (int i = 0; i < 9; i++) wr(2'd0, 32'h100 + i, k);
        rd("status_rd", 2'd2, v);
        check("status_full_drop", v, 32'h2080);
        wr(2'd1, 32'h200, k);
        rd("status_rd", 2'd2, v);
        check("status_drop_clr", v, 32'h80);
        wr(2'd1, 32'h1, k);
        idle(14);
        rd("status_rd", 2'd2, v);
        check("status_after_pkt8", v, 32'h0);

        // Overflow on the second of four pushes, plus a DATA write during PUSH.
        for (int i = 0; i < 4; i++) wr(2'd0, 32'hB0 + i, k);
        wr(2'd1, 32'h1, k);
        while (cycle < k + 4) idle(1);
        ovf_in = 1'b1;
        idle(1);
        ovf_in = 1'b0;
        wr(2'd0, 32'h77, k);
        idle(2);
        rd("status_rd", 2'd2, v);
        check("status_ovf_cnt1", v, 32'h1010);
        wr(2'd1, 32'h101, k);
        idle(5);
        rd("status_rd", 2'd2, v);
        check("status_ovf_clr_send", v, 32'h0);
        check("data_hold_77", fb_data, 32'h77);

        // SEND on empty FIFO, then SEND during PUSH; IRQ enabled where built in.
        wr(2'd1, 32'h3, k);
        idle(4);
        rd("status_rd", 2'd2, v);
        check("status_empty_send", v, IRQ_ST);
        wr(2'd0, 32'hC0, k);
        wr(2'd0, 32'hC1, k);
        wr(2'd1, 32'h3, k);
        wr(2'd1, 32'h3, k);
        idle(6);
        rd("status_rd", 2'd2, v);
        check("status_after_resend", v, IRQ_ST);
        wr(2'd0, 32'hD0, k);
        wr(2'd1, 32'h3, k);
        idle(5);
        check("irq_pulses", 32'(irq_count), IRQ_NPKT);

        // Reset in the middle of a packet.
        for (int i = 0; i < 4; i++) wr(2'd0, 32'hE0 + i, k);
        wr(2'd1, 32'h1, k);
        while (cycle < k + 4) idle(1);
        check("mid_push_active", 32'(fb_push), 32'hF);
        rst_n = 1'b0;
        model_reset();
        #1;
        check("mid_rst_push", 32'(fb_push), 32'd0);
        check("mid_rst_data", fb_data, 32'd0);
        check("mid_rst_sof",  32'(fb_sof), 32'd0);
        check("mid_rst_eof",  32'(fb_eof), 32'd0);
        check("mid_rst_irq",  32'(irq), 32'd0);
        idle(2);
        rst_n = 1'b1;
        idle(1);
        rd("status_rd", 2'd2, v);
        check("status_after_mid_rst", v, 32'h0);

        idle(5);
        check("exp_drained", 32'(exp_q.size()), 32'd0);
        check("irq_drained", 32'(irq_q.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation time limit reached at cycle %0d", cycle);
        $fatal(1, "watchdog expired");
    end

endmodule

`default_nettype wire

// File: doc/pkfb_wb_writer.md
PKFB_WB_WRITER -- requirements
Module: pkfb_wb_writer

Interface
REQ-001 The block SHALL have a parameter FIFO_DEPTH, default 8, giving the data FIFO depth in words; the value SHALL be a power of two from 2 to 16.
REQ-002 The block SHALL have the following ports:
- WB_CLK  in  1  — the single clock; it also clocks the packet FIFO push side (Sys_PKfb_Clk is driven from WB_CLK externally).
- WB_RST_N  in  1  — asynchronous, active-low reset.
- WBs_CYC  in  1  — Wishbone cycle.
- WBs_STB  in  1  — Wishbone strobe.
- WBs_WE  in  1  — write enable.
- WBs_BYTE_STB  in  4  — byte strobes; ignored, every access is a full word.
- WBs_ADR  in  17  — address; only bits [3:2] are decoded.
- WBs_WR_DAT  in  32  — write data.
- WBs_RD_DAT  out  32  — read data.
- WBs_ACK  out  1  — acknowledge.
- FB_PKfbData  out  32  — packet word.
- FB_PKfbPush  out  4  — push strobes, per byte lane.
- FB_PKfbSOF  out  1  — start of packet.
- FB_PKfbEOF  out  1  — end of packet.
- FB_PKfbOverflow  in  1  — overflow flag from the packet FIFO.
- Pkt_Done_Irq  out  1  — packet-done interrupt pulse.

Function
REQ-003 Register map, decoded on WBs_ADR[3:2]:
- 0 = DATA (write only).
- 1 = CTRL (write only).
- 2 = STATUS (read only).
- 3 = reserved; reads return 0, writes are ignored.
REQ-004 A Wishbone access SHALL be acknowledged with WBs_ACK high for exactly one cycle, in the cycle after the first cycle in which WBs_CYC&WBs_STB is high and WBs_ACK is low.
REQ-005 WBs_RD_DAT SHALL be valid while WBs_ACK is high and SHALL be 0 otherwise.
REQ-006 A DATA write SHALL enqueue WBs_WR_DAT when the FIFO is not full.
REQ-007 A DATA write to a full FIFO SHALL drop the word, set sticky DROP, and still be acknowledged.
REQ-008 A CTRL write with bit0=1 (SEND) while IDLE and with count>0 SHALL latch LEN=count and move the FSM to PUSH.
REQ-009 SEND while not IDLE, or with count=0, SHALL be ignored.
REQ-010 CTRL bit8=1 SHALL clear OVF; CTRL bit9=1 SHALL clear DROP; clears SHALL be honoured in the same write as SEND.
REQ-011 STATUS SHALL read as:
- bit0 = busy (FSM not IDLE).
- bits[8:4] = FIFO count.
- bit12 = OVF.
- bit13 = DROP.
- all other bits 0.
REQ-012 FSM states: IDLE, PUSH, DONE.
- IDLE -> PUSH on a valid SEND.
- PUSH -> DONE after LEN words have been pushed.
- DONE -> IDLE after one cycle.
REQ-013 In PUSH, the block SHALL pop one word per cycle and drive it registered:
- FB_PKfbData = word.
- FB_PKfbPush = 4'b1111.
- FB_PKfbSOF high on word 1 only.
- FB_PKfbEOF high on word LEN only.
REQ-014 When LEN=1, FB_PKfbSOF and FB_PKfbEOF SHALL be high in the same cycle.
REQ-015 Latency: the first push SHALL occur in the second cycle after the SEND ACK cycle; the LEN pushes SHALL be on consecutive cycles.
REQ-016 Outside PUSH, FB_PKfbPush, FB_PKfbSOF and FB_PKfbEOF SHALL be 0, and FB_PKfbData SHALL hold its last value.
REQ-017 FB_PKfbOverflow sampled high in any push cycle SHALL set sticky OVF; the packet SHALL still complete.
REQ-018 A DATA write during PUSH SHALL be accepted if the FIFO is not full. In a cycle with both a push and a pop, the count SHALL be unchanged and the new word SHALL NOT be part of the current packet.
REQ-019 The FIFO count SHALL saturate at FIFO_DEPTH and never wrap; the FIFO SHALL never pop when empty.

Reset
REQ-020 While WB_RST_N is low, all of the following SHALL be cleared immediately:
- FSM returns to IDLE.
- FIFO pointers and count = 0.
- OVF, DROP and LEN = 0.
- WBs_ACK = 0 and WBs_RD_DAT = 0.
- FB_PKfbData = 0, FB_PKfbPush = 0, FB_PKfbSOF = 0, FB_PKfbEOF = 0.
- Pkt_Done_Irq = 0.
REQ-021 A reset during PUSH SHALL abandon the packet with no EOF emitted.
REQ-022 Reset deassertion SHALL take effect on the next WB_CLK rising edge.

Configuration
REQ-023 With PKFB_WB_WRITER_IRQ_EN defined:
- CTRL bit1 is IRQ_EN, a stored bit that resets to 0.
- Pkt_Done_Irq pulses high for one cycle in DONE when IRQ_EN=1.
- STATUS bit2 reflects IRQ_EN.
REQ-024 Without PKFB_WB_WRITER_IRQ_EN:
- Pkt_Done_Irq is tied to 0.
- CTRL bit1 is ignored.
- STATUS bit2 reads 0.

Structure
REQ-025 Package pkfb_pkg SHALL hold:
- the register index constants (DATA, CTRL, STATUS).
- the CTRL and STATUS bit positions.
- the FSM state enum.
REQ-026 The FIFO SHALL be the sub-module pkfb_sync_fifo, a single-clock FIFO with parameter DEPTH, outputs full/empty/count, and first-word-fall-through read.

Verification
REQ-027 The bench SHALL cover the following directed scenarios:
- Write DATA 0xA0,0xA1,0xA2, then SEND -> three consecutive pushes; SOF with 0xA0, EOF with 0xA2; STATUS then reads 0.
- Write DATA 0x55 then SEND -> one push with SOF=EOF=1 and data 0x55.
- Write 9 DATA words with FIFO_DEPTH=8 -> STATUS count=8, DROP=1; CTRL bit9 clears DROP.
- Hold FB_PKfbOverflow high during the second of 4 pushes -> OVF=1, all 4 words pushed, EOF on word 4.
- SEND with an empty FIFO, then SEND during PUSH -> no extra pushes, FSM stays consistent; with IRQ_EN=1, exactly one Pkt_Done_Irq pulse per packet.
- Assert WB_RST_N low mid-PUSH -> outputs 0 immediately, no EOF; after release, STATUS=0.
